rr_arbiter16: RTL

RR_ARBITER16 -- requirements
Module: rr_arbiter16

---
 rtl/rr_arbiter16.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/rr_arbiter16.sv
// ---------------------------------------------------------------------------
// rr_arbiter16 -- 16-requester round-robin arbiter with registered grant.
//
// A grant is held for as long as its requester keeps its req bit high. On
// release, the pointer moves past the released index so that requester has
// the lowest priority next time. A new winner can be granted in the same
// edge as the release, so a busy bus never shows an idle cycle.
//
// Optional feature (macro ARB_TIMEOUT_EN): an 8-bit hold counter revokes a
// grant after MAX_HOLD consecutive cycles and pulses timeout for one cycle.
// Without the macro no counter is built and timeout is tied low.
//
// Ports:
//   clk         in   1   rising-edge clock
//   rst_n       in   1   asynchronous active-low reset
//   req         in  16   level requests, bit i = requester i
//   gnt_valid   out  1   a grant is active
//   gnt_idx     out  4   binary index of the granted requester (0 when idle)
//   gnt_onehot  out 16   one-hot of gnt_idx, all zeros when idle
//   timeout     out  1   one-cycle pulse when a grant is forcibly revoked
// ---------------------------------------------------------------------------
module rr_arbiter16 #(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    output logic        gnt_valid,
    output logic [3:0]  gnt_idx,
    output logic [15:0] gnt_onehot,
    output logic        timeout
);

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arbiter16: MAX_HOLD must be in 1..255");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  ptr_q, ptr_d;
    logic        gnt_valid_q, gnt_valid_d;
    logic [3:0]  gnt_idx_q, gnt_idx_d;
    logic [15:0] gnt_onehot_q, gnt_onehot_d;
    logic [3:0]  nxt_ptr;
    logic [4:0]  win;
    logic        rel;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic        timeout_q, timeout_d;
    logic        revoke;
`endif

    // Returns {found, index} of the first set bit of r searched upward from
    // base, wrapping 15 -> 0.
    function automatic logic [4:0] pick(input logic [15:0] r, input logic [3:0] base);
        logic [4:0] res;
        logic [3:0] k;
        res = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            k = base + 4'(i);
            if (!res[4] && r[k]) res = {1'b1, k};
        end
        return res;
    endfunction

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_valid_d = gnt_valid_q;
        gnt_idx_d   = gnt_idx_q;
        nxt_ptr     = gnt_idx_q + 4'd1;
        win         = '0;
        rel         = 1'b0;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_d  = hold_cnt_q;
        timeout_d   = 1'b0;
        revoke      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                win = pick(req, ptr_q);
                if (win[4]) begin
                    state_d     = GRANT;
                    gnt_valid_d = 1'b1;
                    gnt_idx_d   = win[3:0];
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_d  = '0;
`endif
                end
            end
            GRANT: begin
                rel = !req[gnt_idx_q];
`ifdef ARB_TIMEOUT_EN
                // The decision is taken in the grant's MAX_HOLD-th visible
                // cycle, so the grant is seen for exactly MAX_HOLD cycles.
                revoke     = req[gnt_idx_q] && (hold_cnt_q + 8'd1 == HOLD_LIMIT);
                hold_cnt_d = hold_cnt_q + 8'd1;
                timeout_d  = revoke;
                rel        = rel || revoke;
`endif
                if (rel) begin
                    ptr_d = nxt_ptr;
                    // The outgoing requester is masked so a revoked holder
                    // cannot win its own re-arbitration.
                    win = pick(req & ~(16'h0001 << gnt_idx_q), nxt_ptr);
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_d = '0;
`endif
                    if (win[4]) begin
                        gnt_idx_d = win[3:0];
                    end else begin
                        state_d     = IDLE;
                        gnt_valid_d = 1'b0;
                        gnt_idx_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        gnt_onehot_d = gnt_valid_d ? (16'h0001 << gnt_idx_d) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            gnt_valid_q  <= 1'b0;
            gnt_idx_q    <= '0;
            gnt_onehot_q <= '0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q   <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_valid_q  <= gnt_valid_d;
            gnt_idx_q    <= gnt_idx_d;
            gnt_onehot_q <= gnt_onehot_d;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q   <= hold_cnt_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

    assign gnt_valid  = gnt_valid_q;
    assign gnt_idx    = gnt_idx_q;
    assign gnt_onehot = gnt_onehot_q;
`ifdef ARB_TIMEOUT_EN
    assign timeout    = timeout_q;
`else
    assign timeout    = 1'b0;
`endif

endmodule
